// File: rtl/delta2_bram_single.sv
// Simple dual-port, single-clock block RAM holding delta2 values.
// Port A is write-only, port B is read-only with a 1- or 2-cycle registered read path.
module delta2_bram_single #(
    parameter int DELTA_BRAM_AWIDTH = 15,
    parameter int DELTA_BRAM_DWIDTH = 36,
    parameter int READ_LATENCY      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic                         wea,
    input  logic [DELTA_BRAM_AWIDTH-1:0] addra,
    input  logic [DELTA_BRAM_DWIDTH-1:0] dina,
    input  logic                         enb,
    input  logic [DELTA_BRAM_AWIDTH-1:0] addrb,
    output logic [DELTA_BRAM_DWIDTH-1:0] doutb
);

    localparam int DEPTH = 1 << DELTA_BRAM_AWIDTH;

    // NOTE: the array is zero-filled at configuration through its declaration and is
    // never touched by rst; a reset on the storage would prevent block RAM inference.
    logic [DELTA_BRAM_DWIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    logic [DELTA_BRAM_DWIDTH-1:0] latch_q;

    // NOTE: non-blocking assignments make the same-edge read see the old word,
    // which gives read-first behaviour on an address collision.
    always_ff @(posedge clk) begin
        if (ena && wea && !rst) begin
            mem_q[addra] <= dina;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            latch_q <= '0;
        end else if (enb) begin
            latch_q <= mem_q[addrb];
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign doutb = latch_q;
        end else if (READ_LATENCY == 2) begin : g_lat2
            logic                         en_d_q;
            logic [DELTA_BRAM_DWIDTH-1:0] out_q;

            // The output stage follows the latch one cycle behind, gated by the delayed enable.
            always_ff @(posedge clk) begin
                if (rst) begin
                    en_d_q <= 1'b0;
                    out_q  <= '0;
                end else begin
                    en_d_q <= enb;
                    if (en_d_q) begin
                        out_q <= latch_q;
                    end
                end
            end

            assign doutb = out_q;
        end else begin : g_bad_latency
            $error("delta2_bram_single: READ_LATENCY must be 1 or 2");
        end
    endgenerate

endmodule

// File: tb/tb_delta2_bram_single.sv
// Directed bench driving a READ_LATENCY=2 and a READ_LATENCY=1 instance with identical stimulus.
// Expected doutb values for both latencies are hand-computed per cycle.
module tb_delta2_bram_single;

    localparam int AW = 15;
    localparam int DW = 36;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic          wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dina;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb_l2;
    logic [DW-1:0] doutb_l1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    delta2_bram_single #(
        .DELTA_BRAM_AWIDTH(AW),
        .DELTA_BRAM_DWIDTH(DW),
        .READ_LATENCY(2)
    ) dut_l2 (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .wea  (wea),
        .addra(addra),
        .dina (dina),
        .enb  (enb),
        .addrb(addrb),
        .doutb(doutb_l2)
    );

    delta2_bram_single #(
        .DELTA_BRAM_AWIDTH(AW),
        .DELTA_BRAM_DWIDTH(DW),
        .READ_LATENCY(1)
    ) dut_l1 (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .wea  (wea),
        .addra(addra),
        .dina (dina),
        .enb  (enb),
        .addrb(addrb),
        .doutb(doutb_l1)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // One clock: apply inputs, take the rising edge, then compare both outputs on the falling edge.
    task automatic cyc(input string tag, input logic r,
                       input logic e_a, input logic w_a, input logic [AW-1:0] a_a, input logic [DW-1:0] d_a,
                       input logic e_b, input logic [AW-1:0] a_b,
                       input logic [DW-1:0] exp_l1, input logic [DW-1:0] exp_l2);
        rst   = r;
        ena   = e_a;
        wea   = w_a;
        addra = a_a;
        dina  = d_a;
        enb   = e_b;
        addrb = a_b;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_l1"}, doutb_l1, exp_l1);
        check({tag, "_l2"}, doutb_l2, exp_l2);
    endtask

    localparam logic [AW-1:0] TOP_A = '1;
    localparam logic [DW-1:0] ONES  = '1;

    initial begin
        //   tag           rst ena wea addra  dina  enb addrb  exp_l1 exp_l2
        cyc("reset",        1, 0, 0, 15'd0, 36'd0, 0, 15'd0, 36'd0, 36'd0);
        cyc("cfg_rd0",      0, 0, 0, 15'd0, 36'd0, 1, 15'd0, 36'd0, 36'd0);
        cyc("cfg_rd1",      0, 0, 0, 15'd0, 36'd0, 1, 15'd1, 36'd0, 36'd0);
        cyc("cfg_rd2",      0, 0, 0, 15'd0, 36'd0, 1, 15'd2, 36'd0, 36'd0);
        cyc("wr_a0",        0, 1, 1, 15'd0, 36'd3, 0, 15'd0, 36'd0, 36'd0);
        cyc("wr_a1",        0, 1, 1, 15'd1, 36'd5, 0, 15'd0, 36'd0, 36'd0);
        cyc("rd_a0",        0, 0, 0, 15'd0, 36'd0, 1, 15'd0, 36'd3, 36'd0);
        cyc("rd_a1_rewr",   0, 1, 1, 15'd0, 36'd3, 1, 15'd1, 36'd5, 36'd3);
        cyc("rd_a0_again",  0, 0, 0, 15'd0, 36'd0, 1, 15'd0, 36'd3, 36'd5);
        cyc("collision",    0, 1, 1, 15'd0, 36'd5, 1, 15'd0, 36'd3, 36'd3);
        cyc("after_coll",   0, 0, 0, 15'd0, 36'd0, 1, 15'd0, 36'd5, 36'd3);
        cyc("indep_ports",  0, 1, 1, 15'd3, 36'd8, 1, 15'd4, 36'd0, 36'd5);
        cyc("rd_a3",        0, 0, 0, 15'd0, 36'd0, 1, 15'd3, 36'd8, 36'd0);
        cyc("hold1",        0, 1, 1, 15'd3, 36'd9, 0, 15'd3, 36'd8, 36'd8);
        cyc("hold2",        0, 1, 1, 15'd3, 36'd9, 0, 15'd3, 36'd8, 36'd8);
        cyc("hold3",        0, 0, 0, 15'd0, 36'd0, 0, 15'd3, 36'd8, 36'd8);
        cyc("rd_a3_new",    0, 0, 0, 15'd0, 36'd0, 1, 15'd3, 36'd9, 36'd8);
        cyc("rd_a1_flight", 0, 0, 0, 15'd0, 36'd0, 1, 15'd1, 36'd5, 36'd9);
        cyc("mid_reset",    1, 1, 1, 15'd1, 36'd7, 1, 15'd1, 36'd0, 36'd0);
        cyc("post_reset",   0, 0, 0, 15'd0, 36'd0, 0, 15'd0, 36'd0, 36'd0);
        cyc("rd_a1_kept",   0, 0, 0, 15'd0, 36'd0, 1, 15'd1, 36'd5, 36'd0);
        cyc("rd_a1_out",    0, 0, 0, 15'd0, 36'd0, 0, 15'd0, 36'd5, 36'd5);
        cyc("wr_top",       0, 1, 1, TOP_A, ONES,  0, 15'd0, 36'd5, 36'd5);
        cyc("rd_top",       0, 0, 0, 15'd0, 36'd0, 1, TOP_A, ONES,  36'd5);
        cyc("rd_top_out",   0, 0, 0, 15'd0, 36'd0, 0, 15'd0, ONES,  ONES);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
